// File: rtl/sprite_fetch_ctrl_pkg.sv
// Display timing constants, bus field types and origin-update FSM encoding shared by the sprite fetch controller.
// Latency/backpressure: not applicable (types and constants only).
package sprite_fetch_ctrl_pkg;

  localparam int H_ACTIVE = 1024;
  localparam int HTOTAL   = 1344;
  localparam int V_ACTIVE = 768;
  localparam int VTOTAL   = 806;

  typedef logic [10:0] hpos_t;
  typedef logic [9:0]  vpos_t;
  typedef logic [16:0] rom_addr_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_ACK     = 2'd2
  } upd_state_t;

endpackage

// File: rtl/sprite_fetch_ctrl_if.sv
// Raster position, origin-update request/ack handshake and ROM fetch outputs of the sprite fetch controller.
// Latency/backpressure: wires only; the requester holds upd_req until upd_ack.
interface sprite_fetch_ctrl_if;
  import sprite_fetch_ctrl_pkg::*;

  hpos_t     hcount;
  vpos_t     vcount;
  hpos_t     new_x;
  vpos_t     new_y;
  logic      upd_req;
  logic      upd_ack;
  hpos_t     x_cur;
  vpos_t     y_cur;
  rom_addr_t rom_addr;
  logic      rom_en;
  logic      pix_valid;

  modport master (
    output hcount, vcount, new_x, new_y, upd_req,
    input  upd_ack, x_cur, y_cur, rom_addr, rom_en, pix_valid
  );

  modport slave (
    input  hcount, vcount, new_x, new_y, upd_req,
    output upd_ack, x_cur, y_cur, rom_addr, rom_en, pix_valid
  );

endinterface

// File: rtl/sprite_fetch_ctrl_fetch_delay_pipe.sv
// Delays the fetch-enable by LATENCY cycles to qualify the pixel arriving from ROM and colour map.
// Latency: LATENCY cycles; no backpressure, shifts every cycle.
module fetch_delay_pipe #(
  parameter int LATENCY = 2
) (
  input  logic pixel_clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic [LATENCY-1:0] sr;

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      sr <= '0;
    end else begin
      sr[0] <= din;
      for (int i = 1; i < LATENCY; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  assign dout = sr[LATENCY-1];

endmodule

// File: rtl/sprite_fetch_ctrl.sv
// Sprite ROM address generator with vblank-committed origin updates; rom_addr/rom_en one cycle after the raster
// position, pix_valid LATENCY cycles after rom_en; update requests wait in PENDING until the commit point.
module sprite_fetch_ctrl #(
  parameter int WIDTH    = 400,
  parameter int HEIGHT   = 300,
  parameter int LATENCY  = 2,
  parameter int V_ACTIVE = sprite_fetch_ctrl_pkg::V_ACTIVE
) (
  input logic               pixel_clk,
  input logic               reset,
  sprite_fetch_ctrl_if.slave bus
);
  import sprite_fetch_ctrl_pkg::*;

  localparam rom_addr_t ROW_STEP = rom_addr_t'(WIDTH);
  localparam hpos_t     COL_MAX  = hpos_t'(WIDTH - 1);

  upd_state_t state_q, state_d;
  logic       capture, load, ack;

  hpos_t     x_cur_q, shadow_x;
  vpos_t     y_cur_q, shadow_y;
  rom_addr_t rom_addr_q, row_base, rb_eff;
  logic      rom_en_q, line_hit;
  hpos_t     col, col_eff;

  logic [11:0] h12, v12, x_lo, x_hi, y_lo, y_hi;
  logic        in_win, line_start, commit;

  // Window test widened to 12 bits so origin + size cannot wrap.
  assign h12    = {1'b0, bus.hcount};
  assign v12    = {2'b00, bus.vcount};
  assign x_lo   = {1'b0, x_cur_q};
  assign x_hi   = x_lo + 12'(WIDTH);
  assign y_lo   = {2'b00, y_cur_q};
  assign y_hi   = y_lo + 12'(HEIGHT);
  assign in_win = (h12 >= x_lo) && (h12 < x_hi) && (v12 >= y_lo) && (v12 < y_hi);

  assign line_start = (bus.hcount == '0);
  assign commit     = line_start && (bus.vcount == vpos_t'(V_ACTIVE));

  // Row base advances on line starts only, so a truncated row never shifts the next row's base.
  always_comb begin
    rb_eff  = row_base;
    col_eff = col;
    if (line_start) begin
      col_eff = '0;
      if (line_hit) rb_eff = row_base + ROW_STEP;
    end
    if (commit) rb_eff = '0;
  end

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      row_base   <= '0;
      col        <= '0;
      line_hit   <= 1'b0;
      rom_addr_q <= '0;
      rom_en_q   <= 1'b0;
    end else begin
      row_base <= rb_eff;
      rom_en_q <= in_win;
      line_hit <= line_start ? in_win : (line_hit | in_win);
      if (in_win) begin
        rom_addr_q <= rb_eff + rom_addr_t'(col_eff);
        col        <= (col_eff == COL_MAX) ? col_eff : col_eff + hpos_t'(1);
      end else begin
        col <= col_eff;
      end
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      shadow_x <= '0;
      shadow_y <= '0;
      x_cur_q  <= '0;
      y_cur_q  <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        shadow_x <= bus.new_x;
        shadow_y <= bus.new_y;
      end
      if (load) begin
        x_cur_q <= shadow_x;
        y_cur_q <= shadow_y;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    load    = 1'b0;
    ack     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.upd_req) begin
          state_d = ST_PENDING;
          capture = 1'b1;
        end
      end
      ST_PENDING: begin
        if (commit) begin
          state_d = ST_ACK;
          load    = 1'b1;
        end
      end
      ST_ACK: begin
        ack     = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  fetch_delay_pipe #(.LATENCY(LATENCY)) u_delay (
    .pixel_clk (pixel_clk),
    .reset     (reset),
    .din       (rom_en_q),
    .dout      (bus.pix_valid)
  );

  assign bus.upd_ack  = ack;
  assign bus.x_cur    = x_cur_q;
  assign bus.y_cur    = y_cur_q;
  assign bus.rom_addr = rom_addr_q;
  assign bus.rom_en   = rom_en_q;

endmodule
